run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer.sv | 131 +++++++++++++
 tb/tb_run_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/run_sequencer.sv
// Runs programs 0..NUM_PROGS-1 on a core back-to-back, timing each program's RUN phase.
// Latency: go -> LAUNCH next cycle; START_HOLD launch cycles; count_valid one cycle after core_done/timeout.
// Backpressure: none; go is only accepted in IDLE, core_done only observed in RUN.
module run_sequencer #(
  parameter int NUM_PROGS  = 3,
  parameter int START_HOLD = 2,
  parameter int TIMEOUT    = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        core_done,
  output logic        core_start,
  output logic [1:0]  prog_sel,
  output logic        busy,
  output logic        all_done,
  output logic        timeout_err,
  output logic [15:0] cycle_count,
  output logic        count_valid
);

  localparam int                HOLD_W    = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(START_HOLD - 1);
  localparam logic [15:0]       CNT_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0]       CNT_FULL  = 16'(TIMEOUT);
  localparam logic [1:0]        LAST_PROG = 2'(NUM_PROGS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_FINISH
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [15:0]       run_cnt;

  // The core's PC is held at the program entry in every state except RUN.
  assign core_start = (state != S_RUN);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; core_done beats the timeout when both occur together.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (go) state_nxt = S_LAUNCH;
      S_LAUNCH: if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
      S_RUN: begin
        if (core_done) begin
          state_nxt = S_NEXT;
        end else if (run_cnt == CNT_LAST) begin
          state_nxt = S_FINISH;
        end
      end
      S_NEXT:   state_nxt = (prog_sel == LAST_PROG) ? S_FINISH : S_LAUNCH;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Counters, program index and status flags, updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt    <= '0;
      run_cnt     <= '0;
      prog_sel    <= '0;
      busy        <= 1'b0;
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
      cycle_count <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            prog_sel    <= '0;
            all_done    <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        S_LAUNCH: begin
          if (hold_cnt == HOLD_LAST) begin
            run_cnt  <= '0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (core_done) begin
            cycle_count <= run_cnt;
            count_valid <= 1'b1;
          end else if (run_cnt == CNT_LAST) begin
            // Abort the whole sequence; prog_sel keeps pointing at the culprit.
            timeout_err <= 1'b1;
            cycle_count <= CNT_FULL;
            count_valid <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 16'd1;
          end
        end
        S_NEXT: begin
          if (prog_sel != LAST_PROG) begin
            prog_sel <= prog_sel + 2'd1;
            hold_cnt <= '0;
          end
        end
        S_FINISH: begin
          busy     <= 1'b0;
          all_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with NUM_PROGS=3, START_HOLD=2, TIMEOUT=100.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable; every wait is a fixed number of cycles.
module tb_run_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic        core_done;
  logic        core_start;
  logic [1:0]  prog_sel;
  logic        busy;
  logic        all_done;
  logic        timeout_err;
  logic [15:0] cycle_count;
  logic        count_valid;

  int checks = 0;
  int errors = 0;

  run_sequencer #(
    .NUM_PROGS  (3),
    .START_HOLD (2),
    .TIMEOUT    (100)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .core_done   (core_done),
    .core_start  (core_start),
    .prog_sel    (prog_sel),
    .busy        (busy),
    .all_done    (all_done),
    .timeout_err (timeout_err),
    .cycle_count (cycle_count),
    .count_valid (count_valid)
  );

  // 10-unit clock period.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_core_start"},  16'(core_start),  16'd1);
    chk({tag, "_prog_sel"},    16'(prog_sel),    16'd0);
    chk({tag, "_busy"},        16'(busy),        16'd0);
    chk({tag, "_all_done"},    16'(all_done),    16'd0);
    chk({tag, "_timeout_err"}, 16'(timeout_err), 16'd0);
    chk({tag, "_cycle_count"}, cycle_count,      16'd0);
    chk({tag, "_count_valid"}, 16'(count_valid), 16'd0);
  endtask

  // Entered on the first LAUNCH cycle of program exp_sel. core_done is raised
  // on RUN cycle done_cyc (counter = done_cyc-1). With noise set, core_done is
  // pulsed in LAUNCH and go is pulsed in RUN; neither may alter the timing.
  task automatic run_prog(input int done_cyc, input logic [1:0] exp_sel,
                          input bit last, input bit noise);
    chk("launch1_core_start", 16'(core_start), 16'd1);
    chk("launch1_busy",       16'(busy),       16'd1);
    chk("launch1_prog_sel",   16'(prog_sel),   16'(exp_sel));
    if (noise) core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("launch2_core_start", 16'(core_start), 16'd1);
    step();
    for (int i = 1; i < done_cyc; i++) begin
      chk("run_core_start",  16'(core_start),  16'd0);
      chk("run_count_valid", 16'(count_valid), 16'd0);
      if (noise && i == 3) go = 1'b1;
      step();
      go = 1'b0;
    end
    chk("run_last_core_start", 16'(core_start), 16'd0);
    core_done = 1'b1;
    step();
    core_done = 1'b0;
    chk("next_count_valid", 16'(count_valid), 16'd1);
    chk("next_cycle_count", cycle_count,      16'(done_cyc - 1));
    chk("next_prog_sel",    16'(prog_sel),    16'(exp_sel));
    chk("next_timeout_err", 16'(timeout_err), 16'd0);
    chk("next_core_start",  16'(core_start),  16'd1);
    step();
    chk("after_next_count_valid", 16'(count_valid), 16'd0);
    if (last) begin
      chk("finish_busy",     16'(busy),     16'd1);
      chk("finish_all_done", 16'(all_done), 16'd0);
      step();
      chk("idle_all_done",   16'(all_done),   16'd1);
      chk("idle_busy",       16'(busy),       16'd0);
      chk("idle_core_start", 16'(core_start), 16'd1);
      chk("idle_prog_sel",   16'(prog_sel),   16'(exp_sel));
    end else begin
      chk("relaunch_prog_sel", 16'(prog_sel), 16'(exp_sel) + 16'd1);
    end
  endtask

  task automatic start_seq();
    go = 1'b1;
    step();
    go = 1'b0;
    chk("go_all_done_cleared",    16'(all_done),    16'd0);
    chk("go_timeout_err_cleared", 16'(timeout_err), 16'd0);
  endtask

  initial begin
    reset     = 1'b1;
    go        = 1'b0;
    core_done = 1'b0;

    // Reset held two cycles.
    step();
    step();
    chk_reset_values("rst");
    reset = 1'b0;
    step();
    chk_reset_values("idle_after_rst");

    // Nominal sequence: every program finishes on RUN cycle 11.
    start_seq();
    run_prog(11, 2'd0, 1'b0, 1'b0);
    run_prog(11, 2'd1, 1'b0, 1'b0);
    run_prog(11, 2'd2, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_all_done", 16'(all_done),   16'd1);
      chk("hold_busy",     16'(busy),       16'd0);
      chk("hold_start",    16'(core_start), 16'd1);
    end

    // Same sequence with stray go in RUN and stray core_done in LAUNCH.
    start_seq();
    run_prog(11, 2'd0, 1'b0, 1'b1);
    run_prog(11, 2'd1, 1'b0, 1'b1);
    run_prog(11, 2'd2, 1'b1, 1'b1);

    // Timeout: program 0 never signals done.
    start_seq();
    step();
    step();
    for (int i = 1; i < 100; i++) step();
    chk("to_run100_core_start",  16'(core_start),  16'd0);
    chk("to_run100_timeout_err", 16'(timeout_err), 16'd0);
    step();
    chk("to_finish_count_valid", 16'(count_valid), 16'd1);
    chk("to_finish_cycle_count", cycle_count,      16'd100);
    chk("to_finish_timeout_err", 16'(timeout_err), 16'd1);
    chk("to_finish_prog_sel",    16'(prog_sel),    16'd0);
    chk("to_finish_core_start",  16'(core_start),  16'd1);
    step();
    chk("to_idle_all_done",    16'(all_done),    16'd1);
    chk("to_idle_busy",        16'(busy),        16'd0);
    chk("to_idle_count_valid", 16'(count_valid), 16'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("to_no_launch_busy",  16'(busy),        16'd0);
      chk("to_sticky_err",      16'(timeout_err), 16'd1);
      chk("to_prog_sel_stays",  16'(prog_sel),    16'd0);
    end

    // Boundary: done on the same cycle the timeout would fire.
    start_seq();
    run_prog(100, 2'd0, 1'b0, 1'b0);
    run_prog(11,  2'd1, 1'b0, 1'b0);
    run_prog(11,  2'd2, 1'b1, 1'b0);
    chk("boundary_no_err", 16'(timeout_err), 16'd0);

    // Reset in RUN of program 1, with core_done asserted alongside it.
    start_seq();
    run_prog(11, 2'd0, 1'b0, 1'b0);
    step();
    step();
    step();
    step();
    chk("pre_rst_prog_sel",   16'(prog_sel),   16'd1);
    chk("pre_rst_core_start", 16'(core_start), 16'd0);
    reset     = 1'b1;
    core_done = 1'b1;
    step();
    reset     = 1'b0;
    core_done = 1'b0;
    chk_reset_values("mid_rst");
    step();
    chk("post_rst_idle_start", 16'(core_start), 16'd1);
    chk("post_rst_idle_busy",  16'(busy),       16'd0);
    start_seq();
    run_prog(11, 2'd0, 1'b0, 1'b0);
    run_prog(11, 2'd1, 1'b0, 1'b0);
    run_prog(11, 2'd2, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
